uart_rx_fifo: RTL and testbench

//  Next-generation UART receiver: 16x-oversampled majority-vote sampling, optional parity,

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity mode, receiver FSM states,
// the FIFO entry layout and the 3-sample majority vote.
package uart_pkg;

  localparam int MAX_PAYLOAD = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  // Payload is sized for the widest frame; narrower frames leave the top bits zero.
  typedef struct packed {
    logic                   brk;
    logic                   frame_err;
    logic                   parity_err;
    logic [MAX_PAYLOAD-1:0] data;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through register FIFO with occupancy count and a drop strobe
// for pushes refused while full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & ((count != FULL) | do_pop);
  assign drop    = push & ~do_push;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit decisions, parity/framing/break
// detection, feeding a FWFT FIFO with a valid/ready drain port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int OVERSAMPLE   = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  output logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_err
);

  localparam int OS_DIV = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int DIV_W  = $clog2(OS_DIV + 1);
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(PAYLOAD_BITS);
  localparam int STOP_W = $clog2(STOP_BITS) + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(OS_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] VOTE_LO   = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] VOTE_MID  = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] VOTE_HI   = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
  localparam parity_e           PAR_MODE  = parity_e'(PARITY);

  rx_state_e               state, next_state;
  logic                    rxd_meta, rxd_sync, rxd_prev, fall_edge;
  logic [DIV_W-1:0]        div_cnt;
  logic [SAMP_W-1:0]       samp_cnt;
  logic                    tick, vote_stb, clr_samp, bit_val, par_bad, frame_now;
  logic [1:0]              votes;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [STOP_W-1:0]       stop_cnt;
  logic                    par_err, frm_err, push, drop, fifo_valid;
  rx_entry_t               push_entry, head;

  // Synchroniser resets to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rxd_prev, rxd_sync, rxd_meta} <= 3'b111;
    else       {rxd_prev, rxd_sync, rxd_meta} <= {rxd_sync, rxd_meta, uart_rxd};
  end
  assign fall_edge = rxd_prev & ~rxd_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     div_cnt <= '0;
    else if (state == ST_IDLE || div_cnt == DIV_LAST) div_cnt <= '0;
    else                                           div_cnt <= div_cnt + DIV_W'(1);
  end
  assign tick     = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign vote_stb = tick && (samp_cnt == VOTE_HI);
  assign bit_val  = maj3(votes[0], votes[1], rxd_sync);

  // In BRK_WAIT the sample counter measures how long the line has stayed high.
  assign clr_samp = (state == ST_IDLE) || (state == ST_BRK_WAIT && !rxd_sync) ||
                    (state == ST_STOP && next_state == ST_BRK_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_cnt <= '0;
      votes    <= '0;
    end else if (clr_samp) begin
      samp_cnt <= '0;
    end else if (tick) begin
      samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SAMP_W'(1);
      if (samp_cnt == VOTE_LO)  votes[0] <= rxd_sync;
      if (samp_cnt == VOTE_MID) votes[1] <= rxd_sync;
    end
  end

  always_comb begin
    case (PAR_MODE)
      PAR_ODD:  par_bad = ~(^shreg ^ bit_val);
      PAR_EVEN: par_bad = ^shreg ^ bit_val;
      default:  par_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else if (state == ST_IDLE) begin
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else if (vote_stb) begin
      case (state)
        ST_DATA: begin
          shreg   <= {bit_val, shreg[PAYLOAD_BITS-1:1]};
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
        ST_PARITY: par_err <= par_bad;
        ST_STOP: begin
          stop_cnt <= stop_cnt + STOP_W'(1);
          if (!bit_val) frm_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    case (state)
      ST_IDLE:  if (fall_edge) next_state = ST_START;
      ST_START: if (vote_stb)  next_state = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (vote_stb && bit_cnt == BIT_LAST)
          next_state = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (vote_stb) next_state = ST_STOP;
      ST_STOP:
        if (vote_stb && stop_cnt == STOP_LAST) begin
          push       = 1'b1;
          next_state = bit_val ? ST_IDLE : ST_BRK_WAIT;
        end
      ST_BRK_WAIT:
        if (tick && rxd_sync && samp_cnt == SAMP_LAST) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign frame_now = frm_err | ~bit_val;

  always_comb begin
    push_entry                         = '0;
    push_entry.data[PAYLOAD_BITS-1:0]  = shreg;
    push_entry.parity_err              = par_err;
    push_entry.frame_err               = frame_now;
    push_entry.brk                     = (shreg == '0) & frame_now;
  end

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_entry),
    .pop     (rx_ready),
    .rd_data (head),
    .valid   (fifo_valid),
    .count   (fifo_count),
    .drop    (drop)
  );

  // Set wins over clear so a drop coinciding with clear_err is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_err) overflow <= 1'b0;
  end

  // Head fields are masked when empty so the outputs read 0 rather than stale storage.
  assign rx_valid      = fifo_valid;
  assign rx_data       = fifo_valid ? head.data[PAYLOAD_BITS-1:0] : '0;
  assign rx_parity_err = fifo_valid & head.parity_err;
  assign rx_frame_err  = fifo_valid & head.frame_err;
  assign rx_break      = fifo_valid & head.brk;

  logic unused_head_data;
  assign unused_head_data = ^head.data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized frames
// compared against a parity/framing model computed from the bits actually sent.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  // Clock scaled so one bit is 64 cycles; the 16x oversampling structure is unchanged.
  localparam int CLK_HZ     = 614_400;
  localparam int BIT_RATE   = 9600;
  localparam int P          = 8;
  localparam int STOP_BITS  = 1;
  localparam int PARITY     = 2;
  localparam int OVERSAMPLE = 16;
  localparam int DEPTH      = 8;
  localparam int BIT_CLKS   = (CLK_HZ / (BIT_RATE * OVERSAMPLE)) * OVERSAMPLE;
  localparam int CW         = $clog2(DEPTH) + 1;

  typedef logic [P+2:0] ent_t;  // {break, frame_err, parity_err, data}

  logic          clk = 1'b0, reset = 1'b1, uart_rxd = 1'b1, rx_ready = 1'b0, clear_err = 1'b0;
  logic [P-1:0]  rx_data;
  logic          rx_parity_err, rx_frame_err, rx_break, rx_valid, overflow;
  logic [CW-1:0] fifo_count;

  ent_t sent_q[$];
  ent_t got_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(P), .STOP_BITS(STOP_BITS),
    .PARITY(PARITY), .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_break(rx_break),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .overflow(overflow), .clear_err(clear_err)
  );

  // Record every accepted head entry; sampled mid-cycle, away from the active edge.
  always @(negedge clk)
    if (!reset && rx_valid && rx_ready)
      got_q.push_back({rx_break, rx_frame_err, rx_parity_err, rx_data});

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected entry from the bits put on the line.
  function automatic ent_t model_entry(input logic [P-1:0] d, input logic p, input logic stop_ok);
    int   ones;
    logic perr, ferr;
    ones = $countones(d) + int'(p);
    if (PARITY == 0)      perr = 1'b0;
    else if (PARITY == 1) perr = (ones % 2 == 0);
    else                  perr = (ones % 2 == 1);
    ferr = !stop_ok;
    return {ferr && (d == '0), ferr, perr, d};
  endfunction

  task automatic drive(input logic v, input int clks);
    uart_rxd = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [P-1:0] d, input logic bad_par, input logic bad_stop,
                            input int gap);
    logic p;
    p = (PARITY == 1) ? ~(^d) : ^d;
    p = p ^ bad_par;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < P; i++) drive(d[i], BIT_CLKS);
    if (PARITY != 0) drive(p, BIT_CLKS);
    for (int s = 0; s < STOP_BITS; s++) drive(~bad_stop, BIT_CLKS);
    sent_q.push_back(model_entry(d, p, ~bad_stop));
    drive(1'b1, gap * BIT_CLKS);
  endtask

  task automatic test_reset;
    reset = 1'b1; uart_rxd = 1'b1; rx_ready = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_checks++;
    if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++;
    if ({rx_break, rx_frame_err, rx_parity_err, rx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_head: got %h want 0", {rx_break, rx_frame_err, rx_parity_err, rx_data});
    end
    reset = 1'b0;
    drive(1'b1, 2 * BIT_CLKS);
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", rx_valid); end
  endtask

  task automatic test_clean_byte;
    ent_t g;
    got_q.delete(); sent_q.delete(); rx_ready = 1'b1;
    send_frame(8'h41, 1'b0, 1'b0, 1);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++;
    if (got_q.size() != 1 || g !== ent_t'({3'b000, 8'h41})) begin
      n_fail++;
      $display("FAIL clean_0x41: got %0d entries head %h, want 1 entry %h", got_q.size(), g, {3'b000, 8'h41});
    end
    n_checks++;
    if (rx_valid !== 1'b0 || fifo_count !== '0) begin
      n_fail++; $display("FAIL clean_drained: valid %b count %0d, want 0/0", rx_valid, fifo_count);
    end
  endtask

  task automatic test_parity_error;
    ent_t g;
    got_q.delete(); sent_q.delete();
    send_frame(8'h41, 1'b1, 1'b0, 1);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++;
    if (got_q.size() != 1 || g !== ent_t'({3'b001, 8'h41})) begin
      n_fail++;
      $display("FAIL parity_err: got %0d entries head %h, want 1 entry %h", got_q.size(), g, {3'b001, 8'h41});
    end
  endtask

  task automatic test_false_start;
    ent_t g;
    got_q.delete(); sent_q.delete();
    drive(1'b0, BIT_CLKS / 4);
    drive(1'b1, 2 * BIT_CLKS);
    n_checks++;
    if (got_q.size() != 0 || rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL false_start: got %0d entries valid %b, want 0/0", got_q.size(), rx_valid);
    end
    send_frame(8'hAA, 1'b0, 1'b0, 1);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++;
    if (got_q.size() != 1 || g !== ent_t'({3'b000, 8'hAA})) begin
      n_fail++;
      $display("FAIL after_false_start: got %0d entries head %h, want 1 entry %h", got_q.size(), g, {3'b000, 8'hAA});
    end
  endtask

  task automatic test_break;
    ent_t g;
    got_q.delete(); sent_q.delete();
    drive(1'b0, 3 * (P + 3) * BIT_CLKS);
    drive(1'b1, 2 * BIT_CLKS);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++;
    if (got_q.size() != 1 || g !== model_entry('0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL break_entry: got %0d entries head %h, want 1 entry %h", got_q.size(), g, model_entry('0, 1'b0, 1'b0));
    end
    n_checks++;
    if (g[P+2:P+1] !== 2'b11) begin n_fail++; $display("FAIL break_flags: got %b want 11", g[P+2:P+1]); end
    send_frame(8'h55, 1'b0, 1'b0, 1);
    g = (got_q.size() > 1) ? got_q[1] : 'x;
    n_checks++;
    if (got_q.size() != 2 || g !== ent_t'({3'b000, 8'h55})) begin
      n_fail++;
      $display("FAIL after_break: got %0d entries last %h, want 2 entries last %h", got_q.size(), g, {3'b000, 8'h55});
    end
  endtask

  task automatic test_overflow;
    got_q.delete(); sent_q.delete(); rx_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(P'(i), 1'b0, 1'b0, 1);
    n_checks++;
    if (fifo_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, DEPTH); end
    n_checks++;
    if (overflow !== (sent_q.size() > DEPTH)) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    rx_ready = 1'b1;
    repeat (4 * DEPTH) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != DEPTH) begin n_fail++; $display("FAIL ovf_drain_len: got %0d want %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== sent_q[i]) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, got_q[i], sent_q[i]); end
    end
    n_checks++;
    if (fifo_count !== '0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after_drain: count %0d overflow %b, want 0/1", fifo_count, overflow);
    end
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_frame;
    logic [P-1:0] partial;
    ent_t         g;
    got_q.delete(); sent_q.delete(); rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    n_checks++;
    if (fifo_count !== CW'(1)) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 1", fifo_count); end
    partial = 8'h5A;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(partial[i], BIT_CLKS);
    uart_rxd = 1'b1;
    reset    = 1'b1;
    #1;
    n_checks++;
    if (rx_valid !== 1'b0 || fifo_count !== '0) begin
      n_fail++; $display("FAIL mid_reset: valid %b count %0d, want 0/0", rx_valid, fifo_count);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; rx_ready = 1'b1;
    drive(1'b1, BIT_CLKS);
    got_q.delete(); sent_q.delete();
    send_frame(8'hAD, 1'b0, 1'b0, 1);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++;
    if (got_q.size() != 1 || g !== ent_t'({3'b000, 8'hAD})) begin
      n_fail++;
      $display("FAIL after_mid_reset: got %0d entries head %h, want 1 entry %h", got_q.size(), g, {3'b000, 8'hAD});
    end
  endtask

  task automatic test_random;
    logic bp, bs;
    got_q.delete(); sent_q.delete(); rx_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bp = ($urandom_range(3) == 0);
      bs = ($urandom_range(5) == 0);
      send_frame(P'($urandom), bp, bs, bs ? 2 : 1 + int'($urandom_range(2)));
    end
    n_checks++;
    if (got_q.size() != sent_q.size()) begin
      n_fail++; $display("FAIL rand_len: got %0d want %0d", got_q.size(), sent_q.size());
    end
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== sent_q[i]) begin n_fail++; $display("FAIL rand_entry[%0d]: got %h want %h", i, got_q[i], sent_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_byte();
    test_parity_error();
    test_false_start();
    test_break();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
